// File: rtl/gnn_pkg.sv
// Shared constants and types for the GNN feature loader and its aggregator.
package gnn_pkg;

    localparam int unsigned NUM_NODES = 4;
    localparam int unsigned NUM_FEAT  = 4;
    localparam int unsigned DATA_W    = 21;
    localparam int unsigned NUM_SLOTS = NUM_NODES * NUM_FEAT;
    localparam int unsigned CNT_W     = 4;

    // Count value of the final beat of a batch; the counter saturates here.
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_SLOTS - 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StFire = 2'd2
    } state_e;

    // Bank slot holding feature f of node n (stream order is node-major).
    function automatic int unsigned slot_idx(input int unsigned n, input int unsigned f);
        return NUM_FEAT * n + f;
    endfunction

endpackage

// File: rtl/gnn_feature_loader.sv
// Collects one batch of node features from a beat stream into a register bank,
// then raises a one-cycle strobe for the downstream aggregator.
module gnn_feature_loader
    import gnn_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          flush,
    input  logic                          s_valid,
    input  logic [DATA_W-1:0]             s_data,
    output logic                          s_ready,
    output logic [NUM_SLOTS*DATA_W-1:0]   feat_out,
    output logic                          out_rdy,
    output logic                          busy,
    output logic [CNT_W-1:0]              beat_cnt
);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               s_ready_q;
    logic               busy_q;
    logic               out_rdy_q;
    logic [DATA_W-1:0]  bank_q [NUM_SLOTS];
    logic               accept;

    // A beat lands only while loading; flush wins over acceptance.
    assign accept = (state_q == StLoad) && s_valid && !flush;

    // Batch sequencing with registered handshake/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            out_rdy_q <= 1'b0;
        end else if (flush) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            out_rdy_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q   <= StLoad;
                        cnt_q     <= '0;
                        s_ready_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                StLoad: begin
                    if (s_valid) begin
                        if (cnt_q == LAST_BEAT) begin
                            // Count holds at the last beat through the strobe.
                            state_q   <= StFire;
                            s_ready_q <= 1'b0;
                            out_rdy_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                StFire: begin
                    state_q   <= StIdle;
                    busy_q    <= 1'b0;
                    out_rdy_q <= 1'b0;
                end
                default: begin
                    state_q   <= StIdle;
                    cnt_q     <= '0;
                    s_ready_q <= 1'b0;
                    busy_q    <= 1'b0;
                    out_rdy_q <= 1'b0;
                end
            endcase
        end
    end

    // Feature bank: each accepted beat overwrites the slot named by the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(NUM_SLOTS); k++) begin
                bank_q[k] <= '0;
            end
        end else if (accept) begin
            bank_q[cnt_q] <= s_data;
        end
    end

    for (genvar k = 0; k < int'(NUM_SLOTS); k++) begin : g_flat
        assign feat_out[k*DATA_W +: DATA_W] = bank_q[k];
    end

    assign s_ready  = s_ready_q;
    assign busy     = busy_q;
    assign out_rdy  = out_rdy_q;
    assign beat_cnt = cnt_q;

endmodule

// File: doc/gnn_feature_loader.md
GNN_FEATURE_LOADER -- requirements
Module: gnn_feature_loader

Interface
REQ-001 Parameters (shared package gnn_pkg): NUM_NODES, 4, graph nodes per batch; NUM_FEAT, 4, features per node; DATA_W, 21, signed feature width.
REQ-002 Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin loading one batch; honoured only in IDLE
- flush  in  1  abort the current batch, synchronous
- s_valid  in  1  stream beat valid
- s_data  in  DATA_W signed  stream feature value
- s_ready  out  1  loader accepts a beat this cycle
- feat_out  out  NUM_NODES*NUM_FEAT*DATA_W  flattened feature bank; slot k=4*n+f at bits [k*DATA_W +: DATA_W] (feature f of node n)
- out_rdy  out  1  one-cycle batch-valid strobe, wired to the aggregator's in_rdy_agg
- busy  out  1  high in LOAD or FIRE
- beat_cnt  out  4  number of beats accepted in the current batch

Function
REQ-003 FSM states: IDLE, LOAD, FIRE.
- IDLE -> LOAD when start=1; beat_cnt is cleared on the same edge.
REQ-004 LOAD behaviour:
- s_ready=1.
- A beat is accepted when s_valid&&s_ready; it writes s_data to slot beat_cnt, and beat_cnt increments.
REQ-005 Stream order is node-major: n0 x0..x3, n1 x0..x3, n2, then n3; 16 beats per batch.
REQ-006 Acceptance of the 16th beat (beat_cnt==15) moves LOAD -> FIRE.
- beat_cnt does not wrap; it holds 15 through FIRE.
REQ-007 FIRE lasts exactly one cycle: out_rdy=1 and s_ready=0, then FIRE -> IDLE.
REQ-008 Latency: if the last beat is accepted at edge T, out_rdy is high during the cycle after T. The aggregator result is then valid one cycle later.
REQ-009 feat_out is registered and changes only on accepted beats.
- It is stable throughout FIRE and holds its value in IDLE until the next batch overwrites each slot.
REQ-010 s_valid is ignored outside LOAD: no write and no count change.
REQ-011 start is ignored in LOAD and FIRE.
- A start coinciding with FIRE does not re-arm the loader; it must be reasserted in IDLE.
REQ-012 flush=1 in any state forces IDLE with beat_cnt=0 and out_rdy=0 on the next edge.
- feat_out is left unchanged.
- flush has priority over start and over beat acceptance in the same cycle.
REQ-013 Gaps in s_valid (bubbles) stall LOAD indefinitely with no timeout; the slot contents and count are preserved.
REQ-014 out_rdy is never asserted for a partial batch (fewer than 16 beats).
REQ-015 Values are passed through unmodified: no sign extension, saturation or arithmetic on s_data.

Reset
REQ-016 rst_n low asynchronously forces:
- state to IDLE
- feat_out to 0
- beat_cnt to 0
- out_rdy, s_ready and busy to 0
REQ-017 A reset asserted mid-LOAD discards the partial batch; no out_rdy is produced after release.
REQ-018 Reset release is synchronous to clk. The first start is honoured on the first edge after rst_n is high.

Structure
REQ-019 gnn_pkg holds NUM_NODES, NUM_FEAT, DATA_W, the FSM state enum, and the slot-index function k=4*n+f. The aggregator imports the same constants.
REQ-020 The block is a single module with no sub-modules. The feature bank is a register array flattened onto feat_out.

Verification
REQ-021 Directed scenarios:
- Full batch: start, then 16 back-to-back beats with value 1..16 -> out_rdy high for exactly 1 cycle, the cycle after beat 16; slot 0=1, slot 15=16; aggregator x0_n0_agg = 1+5+9 = 15 one cycle later.
- Signed extremes: beats alternating -1048576 and 1048575 -> feat_out slots hold the exact 21-bit patterns 0x100000 and 0x0FFFFF.
- Bubbles: s_valid toggled 1,0,1,0 across 16 beats -> beat_cnt advances only on valid; out_rdy fires once after the 16th accepted beat.
- Flush at beat_cnt=7 with s_valid=1 in the same cycle -> no write to slot 7, IDLE, beat_cnt=0, no out_rdy; the following full batch behaves normally.
- rst_n pulsed low mid-LOAD (beat_cnt=10) -> feat_out=0, state IDLE immediately; no out_rdy after release.
- start held high through FIRE -> exactly one batch loads; out_rdy not repeated until a new start in IDLE.
